multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM of the multicycle RV32I datapath, sitting directly upstream of the ALU control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback. Per cycle it drives the datapath enables, the mux selects and the 2-bit ALU operation class. It supports lw, sw, R-type (add/sub/slt/or/and), I-type ALU (addi/slti/ori/andi), beq and jal, and stalls on a memory-ready handshake.

## Interface
Parameters:
- none. Widths are fixed by the ISA.

Ports:
- iCLK  in  1  system clock, rising edge
- iRSTn  in  1  asynchronous active-low reset
- iOpcode  in  7  instruction[6:0] from the instruction register
- iZero  in  1  ALU zero flag
- iMemReady  in  1  memory completes the current access this cycle
- oPCWrite  out  1  PC register enable
- oIRWrite  out  1  instruction/OldPC register enable
- oRegWrite  out  1  register file write enable
- oMemWrite  out  1  data memory write strobe
- oAdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- oResultSrc  out  2  00 ALUOut, 01 read data, 10 ALUResult
- oALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- oALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- oImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- oALUOp  out  2  OP_ADD / OP_SUB / OP_ANY, consumed by the ALU control decoder
- oZeroFunct7  out  1  gate funct7 to 0 before the ALU control decoder
- oIllegal  out  1  one-cycle pulse on an unsupported opcode
- oState  out  4  current state, for debug

## Operation
- State is a 4-bit register. Outputs are a combinational decode of state, iOpcode, iZero and iMemReady.
- Every output not listed for a state is 0. oALUOp defaults to OP_ADD.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- State-by-state behaviour:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, OP_ADD, ResultSrc=10.
    - IRWrite and PCWrite both equal iMemReady.
    - Stays in FETCH while iMemReady=0; goes to DECODE when iMemReady=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, OP_ADD. ImmSrc is 10 for beq, 11 for jal, 01 for sw, else 00.
    - lw or sw → MEMADR.
    - R → EXECUTER.
    - I → EXECUTEI.
    - beq → BEQ.
    - jal → JAL.
    - Any other opcode → FETCH with oIllegal=1. The PC was already advanced, so the instruction acts as a nop.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, OP_ADD, ImmSrc as in DECODE. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Waits for iMemReady, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 is held every cycle until iMemReady, then → FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, OP_ANY → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, OP_ANY, oZeroFunct7=1 → ALUWB. The zeroed funct7 keeps addi with imm[10]=1 from decoding as sub.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, OP_SUB, ResultSrc=00, PCWrite=iZero → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, OP_ADD, ResultSrc=00, PCWrite=1 → ALUWB, which writes PC+4 to rd.
- Unused state encodings → FETCH on the next edge. All outputs are 0 in those encodings.

## Timing
- Reset:
  - Asynchronous: iRSTn=0 forces FETCH immediately, including mid-instruction. The state register holds FETCH while iRSTn=0.
  - After reset, every output is the FETCH decode: write enables are 0 while iMemReady=0, oALUOp=OP_ADD, oALUSrcB=10, oResultSrc=10, all others 0.
- Cycles per instruction at zero wait states:
  - lw 5.
  - sw 4.
  - R-type and I-type 4.
  - jal 4.
  - beq 3.
  - An illegal opcode takes 2.
- Each cycle iMemReady is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay stable during the stall.
- iMemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- iZero is sampled only in BEQ, combinationally, in the same cycle.

## Structure
- Shared params.v holds:
  - OP_ADD=2'b00, OP_SUB=2'b01, OP_ANY=2'b10.
  - The opcode constants.
  - The state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.
  - The mux select encodings.
- One optional sub-module, imm_src_decode: opcode → oImmSrc, shared by DECODE and MEMADR.

## Test plan
- Reset: iRSTn low in MEMWRITE → oState=0 without waiting for a clock edge; with iMemReady=0, oMemWrite=0 and oPCWrite=0.
- R-type: opcode 0110011, iMemReady=1 → states 0,1,6,8,0. oALUOp=OP_ANY in state 6; oRegWrite=1 only in state 8.
- lw with stalls: iMemReady low for 2 cycles in FETCH and 1 cycle in MEMREAD → 8 cycles total; oIRWrite pulses once, on the ready cycle.
- sw: oMemWrite stays high across a 3-cycle wait in MEMWRITE, then → FETCH.
- beq: iZero=1 → oPCWrite=1 and OP_SUB in BEQ; iZero=0 → oPCWrite=0.
- Illegal and I-type:
  - Opcode 0000000 → oIllegal pulses for 1 cycle and the FSM returns to FETCH.
  - addi → oZeroFunct7=1 in EXECUTEI.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle RV32I control path: ALU op classes,
// opcodes, state encodings and datapath mux select encodings.
package multicycle_control_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ANY = 2'b10;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;

    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;

endpackage

// File: rtl/multicycle_control_imm_src_decode.sv
// Immediate format select from the opcode; shared by the DECODE and MEMADR
// states so both see the same extension.
module multicycle_control_imm_src_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] imm_src
);

    always_comb begin
        case (opcode)
            OPC_BEQ: imm_src = IMM_B;
            OPC_JAL: imm_src = IMM_J;
            OPC_SW:  imm_src = IMM_S;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, with memory-ready stalls.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic [6:0] iOpcode,
    input  logic       iZero,
    input  logic       iMemReady,
    output logic       oPCWrite,
    output logic       oIRWrite,
    output logic       oRegWrite,
    output logic       oMemWrite,
    output logic       oAdrSrc,
    output logic [1:0] oResultSrc,
    output logic [1:0] oALUSrcA,
    output logic [1:0] oALUSrcB,
    output logic [1:0] oImmSrc,
    output logic [1:0] oALUOp,
    output logic       oZeroFunct7,
    output logic       oIllegal,
    output logic [3:0] oState
);

    state_t     state;
    state_t     next_state;
    logic [1:0] imm_src;

    multicycle_control_imm_src_decode u_imm_src_decode (
        .opcode  (iOpcode),
        .imm_src (imm_src)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)
            state <= FETCH;
        else
            state <= next_state;
    end

    assign oState = state;

    always_comb begin
        next_state  = FETCH;
        oPCWrite    = 1'b0;
        oIRWrite    = 1'b0;
        oRegWrite   = 1'b0;
        oMemWrite   = 1'b0;
        oAdrSrc     = ADR_PC;
        oResultSrc  = RES_ALUOUT;
        oALUSrcA    = SRCA_PC;
        oALUSrcB    = SRCB_RD2;
        oImmSrc     = IMM_I;
        oALUOp      = OP_ADD;
        oZeroFunct7 = 1'b0;
        oIllegal    = 1'b0;

        case (state)
            FETCH: begin
                oAdrSrc    = ADR_PC;
                oALUSrcA   = SRCA_PC;
                oALUSrcB   = SRCB_FOUR;
                oResultSrc = RES_ALURESULT;
                oIRWrite   = iMemReady;
                oPCWrite   = iMemReady;
                next_state = iMemReady ? DECODE : FETCH;
            end
            DECODE: begin
                // ALUOut captures OldPC + imm, the branch/jump target
                oALUSrcA = SRCA_OLDPC;
                oALUSrcB = SRCB_IMM;
                oImmSrc  = imm_src;
                case (iOpcode)
                    OPC_LW, OPC_SW: next_state = MEMADR;
                    OPC_R:          next_state = EXECUTER;
                    OPC_I:          next_state = EXECUTEI;
                    OPC_BEQ:        next_state = BEQ;
                    OPC_JAL:        next_state = JAL;
                    default: begin
                        next_state = FETCH;
                        oIllegal   = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                oALUSrcA   = SRCA_RD1;
                oALUSrcB   = SRCB_IMM;
                oImmSrc    = imm_src;
                next_state = (iOpcode == OPC_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                oAdrSrc    = ADR_ALUOUT;
                oResultSrc = RES_ALUOUT;
                next_state = iMemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                oResultSrc = RES_RDATA;
                oRegWrite  = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                oAdrSrc    = ADR_ALUOUT;
                oResultSrc = RES_ALUOUT;
                oMemWrite  = 1'b1;
                next_state = iMemReady ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                oALUSrcA   = SRCA_RD1;
                oALUSrcB   = SRCB_RD2;
                oALUOp     = OP_ANY;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                // funct7 forced to zero so addi with imm[10]=1 is not decoded as sub
                oALUSrcA    = SRCA_RD1;
                oALUSrcB    = SRCB_IMM;
                oALUOp      = OP_ANY;
                oZeroFunct7 = 1'b1;
                next_state  = ALUWB;
            end
            ALUWB: begin
                oResultSrc = RES_ALUOUT;
                oRegWrite  = 1'b1;
                next_state = FETCH;
            end
            BEQ: begin
                oALUSrcA   = SRCA_RD1;
                oALUSrcB   = SRCB_RD2;
                oALUOp     = OP_SUB;
                oResultSrc = RES_ALUOUT;
                oPCWrite   = iZero;
                next_state = FETCH;
            end
            JAL: begin
                // ALU forms OldPC + 4 for rd while PC loads the target from ALUOut
                oALUSrcA   = SRCA_OLDPC;
                oALUSrcB   = SRCB_FOUR;
                oALUOp     = OP_ADD;
                oResultSrc = RES_ALUOUT;
                oPCWrite   = 1'b1;
                next_state = ALUWB;
            end
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized and directed bench for multicycle_control against a route-based
// reference model of the instruction sequencing.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rstn;
    logic [6:0] opcode;
    logic       zero;
    logic       rdy;
    logic       pcw, irw, rw, mw, adr, zf7, ill;
    logic [1:0] res, sa, sb, imm, aluop;
    logic [3:0] st;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state = 0;
    int route[$];
    logic [16:0] obs;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    always #5 clk = ~clk;

    multicycle_control dut (
        .iCLK        (clk),
        .iRSTn       (rstn),
        .iOpcode     (opcode),
        .iZero       (zero),
        .iMemReady   (rdy),
        .oPCWrite    (pcw),
        .oIRWrite    (irw),
        .oRegWrite   (rw),
        .oMemWrite   (mw),
        .oAdrSrc     (adr),
        .oResultSrc  (res),
        .oALUSrcA    (sa),
        .oALUSrcB    (sb),
        .oImmSrc     (imm),
        .oALUOp      (aluop),
        .oZeroFunct7 (zf7),
        .oIllegal    (ill),
        .oState      (st)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] exp_outs(input int s, input logic [6:0] opc,
                                             input logic z, input logic r);
        logic p, i, w, m, a, zf, il;
        logic [1:0] rs, ca, cb, im, op, imm_fmt;
        {p, i, w, m, a, zf, il} = '0;
        {rs, ca, cb, im, op} = '0;
        imm_fmt = (opc == BQ) ? 2'b10 : (opc == JL) ? 2'b11 : (opc == SW) ? 2'b01 : 2'b00;
        case (s)
            0:  begin cb = 2'b10; rs = 2'b10; i = r; p = r; end
            1:  begin ca = 2'b01; cb = 2'b01; im = imm_fmt;
                      il = !(opc inside {LW, SW, RT, IT, BQ, JL}); end
            2:  begin ca = 2'b10; cb = 2'b01; im = imm_fmt; end
            3:  begin a = 1'b1; end
            4:  begin rs = 2'b01; w = 1'b1; end
            5:  begin a = 1'b1; m = 1'b1; end
            6:  begin ca = 2'b10; op = 2'b10; end
            7:  begin ca = 2'b10; cb = 2'b01; op = 2'b10; zf = 1'b1; end
            8:  begin w = 1'b1; end
            9:  begin ca = 2'b10; op = 2'b01; p = z; end
            10: begin ca = 2'b01; cb = 2'b10; p = 1'b1; end
            default: ;
        endcase
        return {p, i, w, m, a, rs, ca, cb, im, op, zf, il};
    endfunction

    // Route model: an instruction is a list of post-decode steps; FETCH,
    // MEMREAD and MEMWRITE hold while memory is not ready.
    task automatic model_advance(input logic [6:0] opc, input logic r);
        if (m_state == 0) begin
            if (r) m_state = 1;
        end else if (m_state == 1) begin
            case (opc)
                LW: route = '{2, 3, 4};
                SW: route = '{2, 5};
                RT: route = '{6, 8};
                IT: route = '{7, 8};
                BQ: route = '{9};
                JL: route = '{10, 8};
                default: route = {};
            endcase
            m_state = (route.size() > 0) ? route.pop_front() : 0;
        end else if ((m_state == 3 || m_state == 5) && !r) begin
            m_state = m_state;
        end else begin
            m_state = (route.size() > 0) ? route.pop_front() : 0;
        end
    endtask

    task automatic step(input logic [6:0] opc, input logic r, input logic z);
        opcode = opc;
        rdy    = r;
        zero   = z;
        @(negedge clk);
        obs = {pcw, irw, rw, mw, adr, res, sa, sb, imm, aluop, zf7, ill};
        check_eq("state", 32'(st), 32'(m_state));
        check_eq("outs", 32'(obs), 32'(exp_outs(m_state, opc, z, r)));
        model_advance(opc, r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, cnt;
        bit stalled;
        int s;
        logic [6:0] ropc;
        logic [6:0] legal[7];
        legal = '{LW, SW, RT, IT, BQ, JL, 7'b0000000};

        rstn = 1'b0; opcode = '0; rdy = 1'b0; zero = 1'b0;
        #12;
        check_eq("reset_state", 32'(st), 32'd0);
        obs = {pcw, irw, rw, mw, adr, res, sa, sb, imm, aluop, zf7, ill};
        check_eq("reset_outs", 32'(obs), 32'(exp_outs(0, 7'd0, 1'b0, 1'b0)));
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // R-type at zero wait states
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            s = m_state;
            step(RT, 1'b1, 1'b0);
            if (s == 6) check_eq("r_aluop", 32'(obs[3:2]), 32'd2);
            cnt += int'(obs[14]);
        end
        check_eq("r_regwrite_cnt", cnt, 1);
        check_eq("r_done", 32'(st), 32'd0);

        // lw with 2 FETCH stalls and 1 MEMREAD stall
        n = 0; cnt = 0; stalled = 0;
        do begin
            logic r;
            r = 1'b1;
            if (n < 2) r = 1'b0;
            else if (m_state == 3 && !stalled) begin r = 1'b0; stalled = 1; end
            step(LW, r, 1'b0);
            n++;
            cnt += int'(obs[15]);
        end while ((n < 3 || m_state != 0) && n < 20);
        check_eq("lw_cycles", n, 8);
        check_eq("lw_irwrite_cnt", cnt, 1);

        // sw with a 3-cycle MEMWRITE wait
        step(SW, 1'b1, 1'b0);
        step(SW, 1'b0, 1'b0);
        step(SW, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(SW, 1'b0, 1'b0);
            check_eq("sw_memwrite_wait", 32'(obs[13]), 32'd1);
        end
        step(SW, 1'b1, 1'b0);
        check_eq("sw_memwrite_last", 32'(obs[13]), 32'd1);
        check_eq("sw_done", 32'(st), 32'd0);

        // beq taken and not taken
        for (int zz = 1; zz >= 0; zz--) begin
            step(BQ, 1'b1, 1'b0);
            step(BQ, 1'b1, 1'b0);
            step(BQ, 1'b1, 1'(zz));
            check_eq("beq_pcwrite", 32'(obs[16]), 32'(zz));
            check_eq("beq_aluop", 32'(obs[3:2]), 32'd1);
        end

        // illegal opcode
        step(7'd0, 1'b1, 1'b0);
        step(7'd0, 1'b1, 1'b0);
        check_eq("illegal_pulse", 32'(obs[0]), 32'd1);
        check_eq("illegal_back_fetch", 32'(st), 32'd0);
        step(7'd0, 1'b0, 1'b0);
        check_eq("illegal_clear", 32'(obs[0]), 32'd0);

        // addi
        step(IT, 1'b1, 1'b0);
        step(IT, 1'b1, 1'b0);
        step(IT, 1'b1, 1'b0);
        check_eq("addi_zf7", 32'(obs[1]), 32'd1);
        step(IT, 1'b1, 1'b0);

        // asynchronous reset in MEMWRITE
        step(SW, 1'b1, 1'b0);
        step(SW, 1'b1, 1'b0);
        step(SW, 1'b1, 1'b0);
        check_eq("pre_reset_memwrite", 32'(st), 32'd5);
        rdy = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_eq("async_reset_state", 32'(st), 32'd0);
        check_eq("async_reset_memwrite", 32'(mw), 32'd0);
        check_eq("async_reset_pcwrite", 32'(pcw), 32'd0);
        m_state = 0;
        route.delete();
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // randomized traffic
        ropc = RT;
        for (int i = 0; i < 2000; i++) begin
            if (m_state == 0) begin
                if ($urandom_range(0, 9) == 0) ropc = 7'($urandom);
                else ropc = legal[$urandom_range(0, 6)];
            end
            step(ropc, ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
